player_action_fsm: RTL

PLAYER_ACTION_FSM -- requirements
Module: player_action_fsm

---
 rtl/player_action_fsm.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/player_action_fsm.sv
// player_action_fsm: player movement plus a three-phase attack sequencer.
// Movement steps one position per MOVE_DIV held cycles and saturates at 0 and POS_MAX.
// An attack press starts WINDUP -> ACTIVE -> RECOVER -> IDLE, with exact phase lengths.
// Optional feature macro PLAYER_ATTACK_QUEUE_EN: a press during RECOVER is queued and
// chains straight into a new WINDUP when RECOVER expires, with no IDLE cycle between.
module player_action_fsm #(
  parameter int POS_W           = 8,
  parameter int POS_MAX         = 159,
  parameter int START_POS       = 20,
  parameter int FACE_RIGHT_INIT = 1,
  parameter int MOVE_DIV        = 2,
  parameter int WINDUP_CYC      = 3,
  parameter int ACTIVE_CYC      = 2,
  parameter int RECOVER_CYC     = 4
) (
  input  logic             clk_game,
  input  logic             reset_n,
  input  logic             game_enable,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_attack,
  output logic [POS_W-1:0] pos,
  output logic             facing_right,
  output logic [1:0]       state,
  output logic             attack_start,
  output logic             hit_active,
  output logic             attack_queued
);

  // Phase counter counts 0..CYC-1, so it only needs to hold the largest CYC-1.
  localparam int PH_MAX0 = (WINDUP_CYC > ACTIVE_CYC) ? WINDUP_CYC : ACTIVE_CYC;
  localparam int PH_MAX  = (PH_MAX0 > RECOVER_CYC) ? PH_MAX0 : RECOVER_CYC;
  localparam int PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int MV_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [PH_W-1:0]  PH_WINDUP_LAST  = PH_W'(WINDUP_CYC - 1);
  localparam logic [PH_W-1:0]  PH_ACTIVE_LAST  = PH_W'(ACTIVE_CYC - 1);
  localparam logic [PH_W-1:0]  PH_RECOVER_LAST = PH_W'(RECOVER_CYC - 1);
  localparam logic [MV_W-1:0]  MV_LAST         = MV_W'(MOVE_DIV - 1);
  localparam logic [POS_W-1:0] POS_HI          = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_LO          = '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WINDUP  = 2'd1,
    S_ACTIVE  = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [PH_W-1:0]  r_phase_cnt;
  logic [PH_W-1:0]  w_phase_next;
  logic [MV_W-1:0]  r_move_cnt;
  logic [MV_W-1:0]  w_move_next;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] w_pos_next;
  logic             r_facing;
  logic             w_facing_next;
  logic             r_btn_attack_q;
  logic             r_attack_start;
  logic             w_attack_start_next;
  logic             r_hit_active;
  logic             w_press;
  logic             w_move_req;
  logic             w_phase_last;
`ifdef PLAYER_ATTACK_QUEUE_EN
  logic             r_queued;
  logic             w_queued_next;
`endif

  // Rising edge of the attack button relative to last cycle's sample.
  assign w_press    = btn_attack & ~r_btn_attack_q;
  // Exactly one direction held while idle and running, and no attack this cycle.
  assign w_move_req = game_enable & (r_state == S_IDLE) & (btn_left ^ btn_right) & ~w_press;

  // Last cycle of the current attack phase.
  always_comb begin
    w_phase_last = 1'b0;
    case (r_state)
      S_WINDUP:  w_phase_last = (r_phase_cnt == PH_WINDUP_LAST);
      S_ACTIVE:  w_phase_last = (r_phase_cnt == PH_ACTIVE_LAST);
      S_RECOVER: w_phase_last = (r_phase_cnt == PH_RECOVER_LAST);
      default:   w_phase_last = 1'b0;
    endcase
  end

  // Next-state, counter, position and facing logic; everything holds while disabled.
  always_comb begin
    w_state_next        = r_state;
    w_phase_next        = r_phase_cnt;
    w_move_next         = r_move_cnt;
    w_pos_next          = r_pos;
    w_facing_next       = r_facing;
    w_attack_start_next = 1'b0;
`ifdef PLAYER_ATTACK_QUEUE_EN
    w_queued_next       = r_queued;
`endif
    if (game_enable) begin
      case (r_state)
        S_IDLE: begin
          if (w_press) begin
            w_state_next        = S_WINDUP;
            w_phase_next        = '0;
            w_move_next         = '0;
            w_attack_start_next = 1'b1;
          end else if (w_move_req) begin
            w_facing_next = btn_right;
            if (r_move_cnt == MV_LAST) begin
              // Counter wraps even when the step is suppressed at a bound.
              w_move_next = '0;
              if (btn_right) begin
                if (r_pos != POS_HI) w_pos_next = r_pos + 1'b1;
              end else begin
                if (r_pos != POS_LO) w_pos_next = r_pos - 1'b1;
              end
            end else begin
              w_move_next = r_move_cnt + 1'b1;
            end
          end else begin
            w_move_next = '0;
          end
        end
        S_WINDUP: begin
          w_move_next = '0;
          if (w_phase_last) begin
            w_state_next = S_ACTIVE;
            w_phase_next = '0;
          end else begin
            w_phase_next = r_phase_cnt + 1'b1;
          end
        end
        S_ACTIVE: begin
          w_move_next = '0;
          if (w_phase_last) begin
            w_state_next = S_RECOVER;
            w_phase_next = '0;
          end else begin
            w_phase_next = r_phase_cnt + 1'b1;
          end
        end
        default: begin // S_RECOVER
          w_move_next = '0;
`ifdef PLAYER_ATTACK_QUEUE_EN
          if (w_press) w_queued_next = 1'b1;
          if (w_phase_last) begin
            w_phase_next = '0;
            // A press on the final RECOVER cycle counts as queued too.
            if (r_queued | w_press) begin
              w_state_next        = S_WINDUP;
              w_attack_start_next = 1'b1;
              w_queued_next       = 1'b0;
            end else begin
              w_state_next = S_IDLE;
            end
          end else begin
            w_phase_next = r_phase_cnt + 1'b1;
          end
`else
          if (w_phase_last) begin
            w_state_next = S_IDLE;
            w_phase_next = '0;
          end else begin
            w_phase_next = r_phase_cnt + 1'b1;
          end
`endif
        end
      endcase
    end
  end

  // Attack button sample, taken every cycle regardless of game_enable.
  always_ff @(posedge clk_game or negedge reset_n) begin
    if (!reset_n) r_btn_attack_q <= 1'b0;
    else          r_btn_attack_q <= btn_attack;
  end

  // State, counters, position, facing and registered outputs.
  always_ff @(posedge clk_game or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_phase_cnt    <= '0;
      r_move_cnt     <= '0;
      r_pos          <= POS_W'(START_POS);
      r_facing       <= 1'(FACE_RIGHT_INIT);
      r_attack_start <= 1'b0;
      r_hit_active   <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_phase_cnt    <= w_phase_next;
      r_move_cnt     <= w_move_next;
      r_pos          <= w_pos_next;
      r_facing       <= w_facing_next;
      r_attack_start <= w_attack_start_next;
      r_hit_active   <= (w_state_next == S_ACTIVE);
    end
  end

`ifdef PLAYER_ATTACK_QUEUE_EN
  // Queued-attack flag, set by a RECOVER press and consumed at RECOVER expiry.
  always_ff @(posedge clk_game or negedge reset_n) begin
    if (!reset_n) r_queued <= 1'b0;
    else          r_queued <= w_queued_next;
  end
  assign attack_queued = r_queued;
`else
  assign attack_queued = 1'b0;
`endif

  assign pos          = r_pos;
  assign facing_right = r_facing;
  assign state        = r_state;
  assign attack_start = r_attack_start;
  assign hit_active   = r_hit_active;

endmodule
